// File: rtl/pll_reset_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reset_pkg
//  Description : Shared types and helpers for the PLL reset sequencer.
//                - state_t      : sequencer state encoding
//                - LOCK_CNT_MAX : saturation value of the lock-loss counter
//                - cnt_width()  : width of the shared cycle counter
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_reset_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        REL_MEM   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [7:0] LOCK_CNT_MAX = 8'd255;

    // One spare bit above clog2 of the largest cycle parameter, so the
    // terminal count always fits without wrapping.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_bit.sv
`default_nettype none
// ============================================================================
//  Module      : sync_bit
//  Description : STAGES-deep flop chain bringing an asynchronous level into
//                the clk domain. Resets to 0.
//  Ports       : clk  - clock
//                rst  - synchronous active-high reset
//                i_d  - asynchronous input level
//                o_q  - synchronised level (i_d delayed STAGES cycles)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reset_sequencer
//  Description : Holds the PLL in reset, debounces its lock output and then
//                releases the memory-domain reset followed, after a fixed
//                gap, by the CPU-domain reset. Runs on the free-running board
//                clock. Optional feature macro: LOCK_RETRY_EN (lock timeout
//                and PLL re-reset on lock loss).
//  Ports       : clk            - free-running board clock
//                rst            - synchronous active-high reset
//                pll_locked     - PLL lock output, asynchronous to clk
//                soft_reset_req - one-cycle CPU-only reset request (RUN only)
//                pll_rst        - reset to the PLL
//                rst_mem        - memory-controller domain reset
//                rst_cpu        - CPU domain reset
//                ready          - high only in RUN
//                lock_lost_cnt  - saturating count of lock losses
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 32,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int STAGE_GAP_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       soft_reset_req,
    output logic       pll_rst,
    output logic       rst_mem,
    output logic       rst_cpu,
    output logic       ready,
    output logic [7:0] lock_lost_cnt
);

    localparam int c_cnt_w = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                       STAGE_GAP_CYCLES, LOCK_TIMEOUT_CYCLES);

    localparam logic [c_cnt_w-1:0] c_pll_last    = c_cnt_w'(PLL_RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_stable_last = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last    = c_cnt_w'(STAGE_GAP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_one         = c_cnt_w'(1);

`ifdef LOCK_RETRY_EN
    localparam logic [c_cnt_w-1:0] c_tmo_last    = c_cnt_w'(LOCK_TIMEOUT_CYCLES - 1);
    localparam state_t             c_loss_state  = PLL_RST;
`else
    localparam state_t             c_loss_state  = WAIT_LOCK;
`endif

    logic               w_locked_sync;
    state_t             r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic [7:0]         r_lost, w_lost_nxt;
    logic               r_pll_rst, r_rst_mem, r_rst_cpu, r_ready;
    logic               w_pll_rst_nxt, w_rst_mem_nxt, w_rst_cpu_nxt, w_ready_nxt;
`ifdef LOCK_RETRY_EN
    logic [c_cnt_w-1:0] r_tmo, w_tmo_nxt;
`endif

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync_locked (
        .clk (clk),
        .rst (rst),
        .i_d (pll_locked),
        .o_q (w_locked_sync)
    );

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= PLL_RST;
            r_cnt     <= '0;
            r_lost    <= '0;
            r_pll_rst <= 1'b1;
            r_rst_mem <= 1'b1;
            r_rst_cpu <= 1'b1;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_lost    <= w_lost_nxt;
            r_pll_rst <= w_pll_rst_nxt;
            r_rst_mem <= w_rst_mem_nxt;
            r_rst_cpu <= w_rst_cpu_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

`ifdef LOCK_RETRY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= w_tmo_nxt;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic. The counter is an up-counter that is cleared on
    // every state change; the >= compares keep it from ever running past
    // a terminal count.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lost_nxt  = r_lost;

        unique case (r_state)
            PLL_RST: begin
                if (r_cnt >= c_pll_last) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_one;
                end
            end
            WAIT_LOCK: begin
                if (!w_locked_sync) begin
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= c_stable_last) begin
                    w_state_nxt = REL_MEM;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_one;
                end
`ifdef LOCK_RETRY_EN
                // Completing the stable count in the timeout cycle wins.
                if (w_state_nxt == WAIT_LOCK && r_tmo >= c_tmo_last) begin
                    w_state_nxt = PLL_RST;
                    w_cnt_nxt   = '0;
                end
`endif
            end
            REL_MEM: begin
                if (!w_locked_sync) begin
                    w_state_nxt = c_loss_state;
                    w_cnt_nxt   = '0;
                    w_lost_nxt  = (r_lost == LOCK_CNT_MAX) ? r_lost : r_lost + 8'd1;
                end else if (r_cnt >= c_gap_last) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_one;
                end
            end
            RUN: begin
                // Lock loss takes priority over a simultaneous soft reset.
                if (!w_locked_sync) begin
                    w_state_nxt = c_loss_state;
                    w_cnt_nxt   = '0;
                    w_lost_nxt  = (r_lost == LOCK_CNT_MAX) ? r_lost : r_lost + 8'd1;
                end else if (soft_reset_req) begin
                    w_state_nxt = REL_MEM;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = PLL_RST;
                w_cnt_nxt   = '0;
            end
        endcase
    end

`ifdef LOCK_RETRY_EN
    // Timeout restarts on every entry into WAIT_LOCK.
    always_comb begin
        w_tmo_nxt = '0;
        if (r_state == WAIT_LOCK && w_state_nxt == WAIT_LOCK) begin
            w_tmo_nxt = r_tmo + c_one;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Output decode from the next state, so the registered outputs change
    // on the same edge as the state they belong to.
    // ------------------------------------------------------------------
    always_comb begin
        w_pll_rst_nxt = 1'b0;
        w_rst_mem_nxt = 1'b1;
        w_rst_cpu_nxt = 1'b1;
        w_ready_nxt   = 1'b0;
        unique case (w_state_nxt)
            PLL_RST:   w_pll_rst_nxt = 1'b1;
            WAIT_LOCK: w_pll_rst_nxt = 1'b0;
            REL_MEM:   w_rst_mem_nxt = 1'b0;
            RUN: begin
                w_rst_mem_nxt = 1'b0;
                w_rst_cpu_nxt = 1'b0;
                w_ready_nxt   = 1'b1;
            end
            default:   w_pll_rst_nxt = 1'b1;
        endcase
    end

    assign pll_rst       = r_pll_rst;
    assign rst_mem       = r_rst_mem;
    assign rst_cpu       = r_rst_cpu;
    assign ready         = r_ready;
    assign lock_lost_cnt = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_reset_sequencer
//  Description : Directed self-checking bench for pll_reset_sequencer.
//                The PLL is modelled as locked whenever lock_en is high and
//                its reset input is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

`ifdef LOCK_RETRY_EN
    localparam logic c_retry = 1'b1;
`else
    localparam logic c_retry = 1'b0;
`endif

    localparam int c_sel_mem = 0;
    localparam int c_sel_cpu = 1;
    localparam int c_sel_pll = 2;
    localparam int c_sel_rdy = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       lock_en;
    logic       soft_reset_req;
    logic       pll_locked;
    logic       pll_rst;
    logic       rst_mem;
    logic       rst_cpu;
    logic       ready;
    logic [7:0] lock_lost_cnt;

    int checks = 0;
    int errors = 0;

    assign pll_locked = lock_en & ~pll_rst;

    pll_reset_sequencer #(
        .SYNC_STAGES         (2),
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .STAGE_GAP_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .soft_reset_req (soft_reset_req),
        .pll_rst        (pll_rst),
        .rst_mem        (rst_mem),
        .rst_cpu        (rst_cpu),
        .ready          (ready),
        .lock_lost_cnt  (lock_lost_cnt)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            c_sel_mem: return rst_mem;
            c_sel_cpu: return rst_cpu;
            c_sel_pll: return pll_rst;
            default:   return ready;
        endcase
    endfunction

    // Edges until the selected output equals val; -1 if the bound expires.
    task automatic edges_until(input int sel, input logic val, input int limit, output int n);
        n = 0;
        while (sig(sel) !== val && n < limit) begin
            tick(1);
            n++;
        end
        if (sig(sel) !== val) n = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int to;

        rst            = 1'b1;
        lock_en        = 1'b0;
        soft_reset_req = 1'b0;
        tick(3);
        check("reset_outs", {pll_rst, rst_mem, rst_cpu, ready}, 4'b1110);
        check("reset_cnt", lock_lost_cnt, 0);

        // 1: power-up sequence with the PLL locking as soon as it leaves reset
        lock_en = 1'b1;
        rst     = 1'b0;
        edges_until(c_sel_pll, 1'b0, 20, n);
        check("t1_pll_rst_len", n, 4);
        edges_until(c_sel_mem, 1'b0, 40, n);
        check("t1_mem_release", n, 10);
        check("t1_cpu_held", {rst_cpu, ready}, 2'b10);
        edges_until(c_sel_cpu, 1'b0, 20, n);
        check("t1_cpu_gap", n, 4);
        check("t1_ready", ready, 1);

        // 4: soft reset in RUN
        soft_reset_req = 1'b1;
        tick(1);
        soft_reset_req = 1'b0;
        check("t4_cpu_rst", {rst_mem, rst_cpu, ready}, 3'b010);
        edges_until(c_sel_cpu, 1'b0, 20, n);
        check("t4_cpu_len", n + 1, 5);
        check("t4_after", {rst_mem, ready, pll_rst}, 3'b010);
        check("t4_cnt", lock_lost_cnt, 0);

        // 3: lock loss in RUN, then relock
        lock_en = 1'b0;
        edges_until(c_sel_mem, 1'b1, 20, n);
        check("t3_loss_delay", n, 3);
        check("t3_loss_outs", {pll_rst, rst_cpu, ready}, {c_retry, 2'b10});
        check("t3_cnt", lock_lost_cnt, 1);
        lock_en = 1'b1;
        edges_until(c_sel_mem, 1'b0, 40, n);
        check("t3_relock", n, c_retry ? 14 : 10);
        edges_until(c_sel_rdy, 1'b1, 20, n);
        check("t3_ready", n, 4);

        // 2: lock dropout at stable count 6 restarts the debounce
        lock_en = 1'b0;
        edges_until(c_sel_mem, 1'b1, 20, n);
        check("t2_loss_delay", n, 3);
        check("t2_cnt", lock_lost_cnt, 2);
        edges_until(c_sel_pll, 1'b0, 20, n);
        lock_en = 1'b1;
        tick(6);
        lock_en = 1'b0;
        tick(3);
        check("t2_still_held", rst_mem, 1);
        lock_en = 1'b1;
        edges_until(c_sel_mem, 1'b0, 40, n);
        check("t2_restart", n, 10);
        edges_until(c_sel_rdy, 1'b1, 20, n);
        check("t2_ready", n, 4);

        // Lock loss and soft reset on the same edge: lock loss wins
        lock_en = 1'b0;
        tick(2);
        soft_reset_req = 1'b1;
        tick(1);
        soft_reset_req = 1'b0;
        check("prio_outs", {rst_mem, rst_cpu, ready}, 3'b110);
        check("prio_cnt", lock_lost_cnt, 3);

        // 6: force lock losses until the counter saturates
        to = 0;
        for (int i = 0; i < 297; i++) begin
            lock_en = 1'b1;
            edges_until(c_sel_mem, 1'b0, 30, n);
            if (n < 0) to++;
            lock_en = 1'b0;
            edges_until(c_sel_mem, 1'b1, 30, n);
            if (n < 0) to++;
            if (i == 250) check("t6_cnt_254", lock_lost_cnt, 254);
            if (i == 251) check("t6_cnt_255", lock_lost_cnt, 255);
        end
        check("t6_timeouts", to, 0);
        check("t6_saturated", lock_lost_cnt, 255);
        lock_en = 1'b1;
        edges_until(c_sel_mem, 1'b0, 30, n);
        check("t6_in_rel_mem", {rst_mem, rst_cpu}, 2'b01);
        rst = 1'b1;
        tick(1);
        check("t6_rst_outs", {pll_rst, rst_mem, rst_cpu, ready}, 4'b1110);
        check("t6_rst_cnt", lock_lost_cnt, 0);
        tick(2);

        // 5: PLL never locks
        lock_en = 1'b0;
        rst     = 1'b0;
        edges_until(c_sel_pll, 1'b0, 20, n);
        check("t5_pll_rst_len", n, 4);
`ifdef LOCK_RETRY_EN
        edges_until(c_sel_pll, 1'b1, 100, n);
        check("t5_timeout", n, 32);
        edges_until(c_sel_pll, 1'b0, 20, n);
        check("t5_repulse_len", n, 4);
        edges_until(c_sel_pll, 1'b1, 100, n);
        check("t5_timeout2", n, 32);
`else
        tick(100);
        check("t5_no_repulse", {pll_rst, rst_mem, ready}, 3'b010);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
